// File: rtl/fir_pkg.sv
// Shared constants and FSM state type for the 10-tap FIR sequencing controller.
package fir_pkg;
    localparam int unsigned TAPS = 10;
    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned OW   = DW + CW + 4;

    // Coefficient n lives at SRAM address n; address 0 is never used.
    localparam logic [AW-1:0] FIRST_ADDR = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_OUT
    } state_e;
endpackage

// File: rtl/fir_delay_line.sv
// Sample history: tap 0 holds the newest sample, tap N-1 the oldest.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int unsigned N = TAPS,
    parameter int unsigned W = DW
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                shift_i,
    input  logic                clr_i,
    input  logic [W-1:0]        din_i,
    output logic [N-1:0][W-1:0] taps_o
);
    logic [N-1:0][W-1:0] line_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_q <= '0;
        end else if (clr_i) begin
            line_q <= '0;
        end else if (shift_i) begin
            line_q <= {line_q[N-2:0], din_i};
        end
    end

    assign taps_o = line_q;
endmodule

// File: rtl/fir_mac_ctrl.sv
// FIR sequencer: loads coefficients into the SRAM, then per sample reads them
// back and multiply-accumulates against the delay line.
module fir_mac_ctrl
    import fir_pkg::*;
(
    input  logic                 iClk_12M,
    input  logic                 iRst,
    input  logic                 iCoefUpdate,
    input  logic                 iCoefWrVld,
    input  logic signed [CW-1:0] iCoefWrDt,
    output logic                 oCoefWrRdy,
    input  logic                 iSmplVld,
    input  logic signed [DW-1:0] iSmpl,
    output logic                 oSmplRdy,
    output logic                 oFirVld,
    output logic signed [OW-1:0] oFirOut,
    output logic                 oCsnRam,
    output logic                 oWrnRam,
    output logic [AW-1:0]        oAddrRam,
    output logic [CW-1:0]        oWrDtRam,
    input  logic signed [CW-1:0] iRdDtRam
);
    state_e                   state_q;
    logic [AW-1:0]            cnt_q;
    logic signed [OW-1:0]     acc_q;
    logic signed [OW-1:0]     acc_d;
    logic signed [OW-1:0]     fir_out_q;
    logic                     fir_vld_q;

    logic [TAPS-1:0][DW-1:0]  taps;
    logic signed [DW-1:0]     x_sel;
    logic signed [DW+CW-1:0]  prod;
    logic                     smpl_acc;
    logic                     load_wr;
    logic                     load_done;

    always_comb begin
        smpl_acc  = (state_q == ST_IDLE) && iSmplVld && !iCoefUpdate;
        load_wr   = (state_q == ST_LOAD) && iCoefWrVld;
        load_done = load_wr && (cnt_q == AW'(TAPS));
    end

    fir_delay_line #(
        .N(TAPS),
        .W(DW)
    ) u_delay_line (
        .clk_i  (iClk_12M),
        .rst_i  (iRst),
        .shift_i(smpl_acc),
        .clr_i  (load_done),
        .din_i  (iSmpl),
        .taps_o (taps)
    );

    // Read data lags the address by one cycle, so the coefficient arriving
    // now belongs to address cnt-1 and pairs with tap cnt-2.
    always_comb begin
        x_sel = '0;
        if (state_q == ST_OUT) begin
            x_sel = taps[TAPS-1];
        end else if (state_q == ST_MAC && cnt_q >= AW'(2)) begin
            x_sel = taps[cnt_q - AW'(2)];
        end
        prod  = (DW+CW)'(iRdDtRam) * (DW+CW)'(x_sel);
        acc_d = acc_q + OW'(prod);
    end

    always_comb begin
        oCsnRam  = 1'b1;
        oWrnRam  = 1'b1;
        oAddrRam = '0;
        oWrDtRam = '0;
        if (load_wr) begin
            oCsnRam  = 1'b0;
            oWrnRam  = 1'b0;
            oAddrRam = cnt_q;
            oWrDtRam = iCoefWrDt;
        end else if (state_q == ST_MAC && cnt_q <= AW'(TAPS)) begin
            oCsnRam  = 1'b0;
            oAddrRam = cnt_q;
        end
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            fir_out_q <= '0;
            fir_vld_q <= 1'b0;
        end else begin
            fir_vld_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (iCoefUpdate) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= FIRST_ADDR;
                    end else if (iSmplVld) begin
                        state_q <= ST_MAC;
                        cnt_q   <= FIRST_ADDR;
                    end
                end
                ST_LOAD: begin
                    if (iCoefWrVld) begin
                        cnt_q <= cnt_q + AW'(1);
                        if (cnt_q == AW'(TAPS)) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_MAC: begin
                    acc_q <= (cnt_q == FIRST_ADDR) ? '0 : acc_d;
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == AW'(TAPS)) begin
                        state_q <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    fir_out_q <= acc_d;
                    fir_vld_q <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oCoefWrRdy = (state_q == ST_LOAD);
    assign oSmplRdy   = (state_q == ST_IDLE);
    assign oFirVld    = fir_vld_q;
    assign oFirOut    = fir_out_q;
endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Scenario bench for fir_mac_ctrl with a registered-read SRAM and a
// convolution reference model.
module tb_fir_mac_ctrl;
    import fir_pkg::*;

    localparam int NT = TAPS;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 iCoefUpdate, iCoefWrVld, iSmplVld;
    logic signed [CW-1:0] iCoefWrDt;
    logic signed [DW-1:0] iSmpl;
    logic                 oCoefWrRdy, oSmplRdy, oFirVld;
    logic signed [OW-1:0] oFirOut;
    logic                 oCsnRam, oWrnRam;
    logic [AW-1:0]        oAddrRam;
    logic [CW-1:0]        oWrDtRam;
    logic signed [CW-1:0] iRdDtRam;
    logic [CW-1:0]        sram [0:(1<<AW)-1];

    int     n_chk = 0;
    int     n_pass = 0;
    longint coef_m   [1:NT];
    longint new_coef [1:NT];
    longint hist_m   [NT];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!oCsnRam) begin
            if (!oWrnRam) sram[oAddrRam] <= oWrDtRam;
            else          iRdDtRam <= sram[oAddrRam];
        end
    end

    fir_mac_ctrl dut (
        .iClk_12M   (clk),
        .iRst       (rst),
        .iCoefUpdate(iCoefUpdate),
        .iCoefWrVld (iCoefWrVld),
        .iCoefWrDt  (iCoefWrDt),
        .oCoefWrRdy (oCoefWrRdy),
        .iSmplVld   (iSmplVld),
        .iSmpl      (iSmpl),
        .oSmplRdy   (oSmplRdy),
        .oFirVld    (oFirVld),
        .oFirOut    (oFirOut),
        .oCsnRam    (oCsnRam),
        .oWrnRam    (oWrnRam),
        .oAddrRam   (oAddrRam),
        .oWrDtRam   (oWrDtRam),
        .iRdDtRam   (iRdDtRam)
    );

    function automatic longint rand16();
        logic signed [15:0] r;
        r = 16'($urandom);
        return longint'(r);
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NT; k++) hist_m[k] = 0;
    endfunction

    function automatic void model_take_coefs();
        for (int n = 1; n <= NT; n++) coef_m[n] = new_coef[n];
        model_clear();
    endfunction

    // y = sum over taps of coef[k+1] * x[k], x[0] newest.
    function automatic longint model_push(input longint s);
        longint y;
        y = 0;
        for (int k = NT - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
        hist_m[0] = s;
        for (int k = 0; k < NT; k++) y += coef_m[k+1] * hist_m[k];
        return y;
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic load_coefs(input bit collide, input bit gaps);
        iCoefUpdate = 1'b1;
        if (collide) iSmplVld = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (oCoefWrRdy !== 1'b1 || oSmplRdy !== 1'b0)
            $display("FAIL load_enter: wrrdy=%0b smplrdy=%0b expected 1 0", oCoefWrRdy, oSmplRdy);
        else n_pass++;
        @(negedge clk);
        iCoefUpdate = 1'b0;
        for (int n = 1; n <= NT; n++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    iCoefWrVld  = 1'b0;
                    iCoefUpdate = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    iCoefUpdate = 1'b0;
                end
            end
            iCoefWrVld = 1'b1;
            iCoefWrDt  = CW'(new_coef[n]);
            @(negedge clk);
        end
        iCoefWrVld = 1'b0;
        model_take_coefs();
        n_chk++;
        if (oSmplRdy !== 1'b1 || oCoefWrRdy !== 1'b0)
            $display("FAIL load_exit: smplrdy=%0b wrrdy=%0b expected 1 0", oSmplRdy, oCoefWrRdy);
        else n_pass++;
    endtask

    task automatic run_sample(input longint s, output longint got, output int lat);
        bit acc;
        bit rdy;
        acc = 1'b0;
        got = 0;
        lat = -1;
        iSmplVld = 1'b1;
        iSmpl    = DW'(s);
        for (int i = 0; i < 60 && !acc; i++) begin
            rdy = oSmplRdy;
            @(posedge clk);
            if (rdy) acc = 1'b1;
            @(negedge clk);
        end
        iSmplVld = 1'b0;
        if (acc) begin
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk); #1;
                if (oFirVld) begin
                    lat = i;
                    got = longint'(oFirOut);
                    break;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if (oCoefWrRdy !== 1'b0 || oSmplRdy !== 1'b1 || oFirVld !== 1'b0 || oFirOut !== '0 ||
            oCsnRam !== 1'b1 || oWrnRam !== 1'b1 || oAddrRam !== '0 || oWrDtRam !== '0)
            $display("FAIL reset_values: wrrdy=%0b rdy=%0b vld=%0b out=%0d csn=%0b wrn=%0b addr=%0d wd=%0h expected 0 1 0 0 1 1 0 0",
                     oCoefWrRdy, oSmplRdy, oFirVld, oFirOut, oCsnRam, oWrnRam, oAddrRam, oWrDtRam);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sram_drive();
        logic [CW-1:0] expw;
        longint        s;
        longint        e;
        for (int n = 1; n <= NT; n++) new_coef[n] = rand16();
        iCoefUpdate = 1'b1;
        @(negedge clk);
        iCoefUpdate = 1'b0;
        for (int n = 1; n <= NT; n++) begin
            iCoefWrVld = 1'b1;
            iCoefWrDt  = CW'(new_coef[n]);
            expw       = CW'(new_coef[n]);
            #1;
            n_chk++;
            if (oCsnRam !== 1'b0 || oWrnRam !== 1'b0 || oAddrRam !== AW'(n) || oWrDtRam !== expw)
                $display("FAIL sram_write[%0d]: csn=%0b wrn=%0b addr=%0d wd=%0h expected 0 0 %0d %0h",
                         n, oCsnRam, oWrnRam, oAddrRam, oWrDtRam, n, expw);
            else n_pass++;
            @(negedge clk);
        end
        iCoefWrVld = 1'b0;
        model_take_coefs();
        #1;
        n_chk++;
        if (oCsnRam !== 1'b1 || oWrnRam !== 1'b1 || oAddrRam !== '0 || oWrDtRam !== '0)
            $display("FAIL sram_idle_after_load: csn=%0b wrn=%0b addr=%0d wd=%0h expected 1 1 0 0",
                     oCsnRam, oWrnRam, oAddrRam, oWrDtRam);
        else n_pass++;
        s = rand16();
        e = model_push(s);
        iSmplVld = 1'b1;
        iSmpl    = DW'(s);
        @(posedge clk);
        for (int c = 1; c <= NT; c++) begin
            @(negedge clk);
            iSmplVld = 1'b0;
            n_chk++;
            if (oCsnRam !== 1'b0 || oWrnRam !== 1'b1 || oAddrRam !== AW'(c))
                $display("FAIL sram_read[%0d]: csn=%0b wrn=%0b addr=%0d expected 0 1 %0d",
                         c, oCsnRam, oWrnRam, oAddrRam, c);
            else n_pass++;
        end
        @(negedge clk);
        n_chk++;
        if (oCsnRam !== 1'b1 || oAddrRam !== '0 || oFirVld !== 1'b0)
            $display("FAIL sram_out_cycle: csn=%0b addr=%0d vld=%0b expected 1 0 0", oCsnRam, oAddrRam, oFirVld);
        else n_pass++;
        @(posedge clk); #1;
        n_chk++;
        if (oFirVld !== 1'b1 || longint'(oFirOut) !== e)
            $display("FAIL sram_first_output: vld=%0b out=%0d expected 1 %0d", oFirVld, oFirOut, e);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_impulse();
        longint got;
        longint exp_v;
        int     lat;
        for (int n = 1; n <= NT; n++) new_coef[n] = n;
        load_coefs(1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            run_sample((i == 0) ? 1 : 0, got, lat);
            exp_v = (i < NT) ? i + 1 : 0;
            n_chk++;
            if (got !== exp_v || lat != 11)
                $display("FAIL impulse[%0d]: out=%0d latency=%0d expected %0d latency 11", i, got, lat, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_extremes();
        longint got;
        longint e;
        int     lat;
        for (int n = 1; n <= NT; n++) new_coef[n] = -32768;
        load_coefs(1'b0, 1'b1);
        for (int i = 0; i < NT; i++) begin
            e = model_push(-32768);
            run_sample(-32768, got, lat);
            n_chk++;
            if (got !== e || lat != 11)
                $display("FAIL extreme_neg[%0d]: out=%0d latency=%0d expected %0d latency 11", i, got, lat, e);
            else n_pass++;
        end
        n_chk++;
        if (got !== 64'sd10737418240)
            $display("FAIL extreme_full_scale: out=%0d expected 10737418240", got);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            e = model_push(32767);
            run_sample(32767, got, lat);
            n_chk++;
            if (got !== e)
                $display("FAIL extreme_mixed[%0d]: out=%0d expected %0d", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        longint expq[$];
        longint ramp;
        longint e;
        int     last_acc;
        int     n_acc;
        bit     rdy;
        for (int n = 1; n <= NT; n++) new_coef[n] = rand16();
        load_coefs(1'b0, 1'b1);
        ramp     = longint'($urandom_range(0, 2000)) - 1000;
        last_acc = -1;
        n_acc    = 0;
        for (int cyc = 0; cyc < 120; cyc++) begin
            iSmplVld = (n_acc < 8);
            iSmpl    = DW'(ramp);
            rdy      = oSmplRdy && iSmplVld;
            @(posedge clk);
            if (rdy) begin
                expq.push_back(model_push(ramp));
                if (last_acc >= 0) begin
                    n_chk++;
                    if (cyc - last_acc != 12)
                        $display("FAIL bp_interval: gap=%0d expected 12", cyc - last_acc);
                    else n_pass++;
                end
                last_acc = cyc;
                ramp++;
                n_acc++;
            end
            #1;
            if (oFirVld) begin
                n_chk++;
                if (expq.size() == 0) begin
                    $display("FAIL bp_spurious: out=%0d expected no strobe", oFirOut);
                end else begin
                    e = expq.pop_front();
                    if (longint'(oFirOut) !== e)
                        $display("FAIL bp_output: out=%0d expected %0d", oFirOut, e);
                    else n_pass++;
                end
            end
            @(negedge clk);
        end
        iSmplVld = 1'b0;
        n_chk++;
        if (n_acc != 8 || expq.size() != 0)
            $display("FAIL bp_totals: accepted=%0d pending=%0d expected 8 0", n_acc, expq.size());
        else n_pass++;
    endtask

    task automatic test_collision();
        longint s;
        longint got;
        longint e;
        int     lat;
        for (int n = 1; n <= NT; n++) new_coef[n] = rand16();
        s = rand16();
        if (s == 0) s = 123;
        iSmpl = DW'(s);
        load_coefs(1'b1, 1'b0);
        e = model_push(s);
        run_sample(s, got, lat);
        n_chk++;
        if (got !== e || lat != 11)
            $display("FAIL collision_output: out=%0d latency=%0d expected %0d latency 11", got, lat, e);
        else n_pass++;
    endtask

    task automatic test_reload();
        longint s;
        longint got;
        longint e;
        int     lat;
        for (int n = 1; n <= NT; n++) new_coef[n] = rand16();
        load_coefs(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            s = rand16();
            e = model_push(s);
            run_sample(s, got, lat);
            n_chk++;
            if (got !== e)
                $display("FAIL reload_before[%0d]: out=%0d expected %0d", i, got, e);
            else n_pass++;
        end
        for (int n = 1; n <= NT; n++) new_coef[n] = rand16();
        load_coefs(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            s = rand16();
            e = model_push(s);
            run_sample(s, got, lat);
            n_chk++;
            if (got !== e)
                $display("FAIL reload_after[%0d]: out=%0d expected %0d", i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mac();
        longint got;
        longint exp_v;
        int     lat;
        for (int n = 1; n <= NT; n++) new_coef[n] = n;
        load_coefs(1'b0, 1'b0);
        run_sample(7, got, lat);
        n_chk++;
        if (got !== 7)
            $display("FAIL rstmac_pre: out=%0d expected 7", got);
        else n_pass++;
        iSmplVld = 1'b1;
        iSmpl    = DW'(5);
        @(posedge clk);
        @(negedge clk);
        iSmplVld = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if (oFirVld !== 1'b0 || oFirOut !== '0 || oSmplRdy !== 1'b1 ||
            oCsnRam !== 1'b1 || oWrnRam !== 1'b1 || oAddrRam !== '0 || oWrDtRam !== '0)
            $display("FAIL rstmac_state: vld=%0b out=%0d rdy=%0b csn=%0b wrn=%0b addr=%0d wd=%0h expected 0 0 1 1 1 0 0",
                     oFirVld, oFirOut, oSmplRdy, oCsnRam, oWrnRam, oAddrRam, oWrDtRam);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            run_sample((i == 0) ? 1 : 0, got, lat);
            exp_v = (i < NT) ? i + 1 : 0;
            n_chk++;
            if (got !== exp_v || lat != 11)
                $display("FAIL rstmac_impulse[%0d]: out=%0d latency=%0d expected %0d latency 11", i, got, lat, exp_v);
            else n_pass++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        iCoefUpdate = 1'b0;
        iCoefWrVld  = 1'b0;
        iCoefWrDt   = '0;
        iSmplVld    = 1'b0;
        iSmpl       = '0;
        for (int n = 1; n <= NT; n++) coef_m[n] = 0;
        model_clear();
        test_reset();
        test_sram_drive();
        test_impulse();
        test_extremes();
        test_backpressure();
        test_collision();
        test_reload();
        test_reset_mac();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
